// File: rtl/pkg_fifo_cfg.sv
// pkg_fifo_cfg: default FIFO geometry and the occupancy flag bundle shared by RTL and bench
package pkg_fifo_cfg;
   localparam int DEF_FIFO_WIDTH = 16;
   localparam int DEF_FIFO_DEPTH = 8;
   typedef struct packed {
      logic full;
      logic almostfull;
      logic empty;
      logic almostempty;
   } fifo_flags_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH storage, one sync write port, one sync read port with a resettable read register
module fifo_mem #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q, rdata_d;
   always_comb rdata_d = re ? mem_q[raddr] : rdata_q;
   // storage is deliberately not reset; only the read register is
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end
   assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised synchronous FIFO with occupancy flags and per-request status;
// defining SYNC_FIFO_ERR_CNT_EN adds saturating ovf_cnt/udf_cnt error counters.
module sync_fifo_param
   import pkg_fifo_cfg::*;
#(
   parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int AF_LEVEL   = FIFO_DEPTH - 1,
   parameter int AE_LEVEL   = 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              wr_en,
   input  logic                              rd_en,
   input  logic [FIFO_WIDTH-1:0]             data_in,
   output logic [FIFO_WIDTH-1:0]             data_out,
   output logic                              full,
   output logic                              almostfull,
   output logic                              empty,
   output logic                              almostempty,
   output logic                              wr_ack,
   output logic                              overflow,
   output logic                              underflow,
`ifdef SYNC_FIFO_ERR_CNT_EN
   output logic [7:0]                        ovf_cnt,
   output logic [7:0]                        udf_cnt,
`endif
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 1024 || AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH - 1 ||
       AE_LEVEL < 1 || AE_LEVEL > FIFO_DEPTH - 1 || AE_LEVEL >= AF_LEVEL) begin : g_bad_cfg
      $error("sync_fifo_param: illegal FIFO_DEPTH/AF_LEVEL/AE_LEVEL combination");
   end

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_ack_q, wr_ack_d, overflow_q, overflow_d, underflow_q, underflow_d;
   logic          wr_ok, rd_ok;
   fifo_flags_t   flags;

   // acceptance is judged on the registered count, so full+rd+wr drops the write
   always_comb begin
      wr_ok       = wr_en && (count_q != CW'(FIFO_DEPTH));
      rd_ok       = rd_en && (count_q != '0);
      wr_ptr_d    = wr_ok ? ((wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d    = rd_ok ? ((rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
      count_d     = count_q + CW'(wr_ok) - CW'(rd_ok);
      wr_ack_d    = wr_ok;
      overflow_d  = wr_en && !wr_ok;
      underflow_d = rd_en && !rd_ok;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wr_ack_q    <= wr_ack_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_comb begin
      flags.full        = count_q == CW'(FIFO_DEPTH);
      flags.empty       = count_q == '0;
      flags.almostfull  = (count_q >= CW'(AF_LEVEL)) && !flags.full;
      flags.almostempty = (count_q <= CW'(AE_LEVEL)) && !flags.empty;
   end

   fifo_mem #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH), .AW(PW)) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_ok && rst_n),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .re    (rd_ok),
      .raddr (rd_ptr_q),
      .rdata (data_out)
   );

`ifdef SYNC_FIFO_ERR_CNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d, udf_cnt_q, udf_cnt_d;
   always_comb begin
      ovf_cnt_d = (overflow_d && ovf_cnt_q != 8'hFF) ? ovf_cnt_q + 8'd1 : ovf_cnt_q;
      udf_cnt_d = (underflow_d && udf_cnt_q != 8'hFF) ? udf_cnt_q + 8'd1 : udf_cnt_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_cnt_q <= '0;
         udf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
         udf_cnt_q <= udf_cnt_d;
      end
   end
   assign ovf_cnt = ovf_cnt_q;
   assign udf_cnt = udf_cnt_q;
`endif

   assign count       = count_q;
   assign wr_ack      = wr_ack_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;
   assign full        = flags.full;
   assign almostfull  = flags.almostfull;
   assign empty       = flags.empty;
   assign almostempty = flags.almostempty;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for sync_fifo_param at depth 8 (dut a) and depth 5 (dut b)
module tb_sync_fifo_param;
   import pkg_fifo_cfg::*;

   typedef struct {
      bit          sel;
      logic [15:0] dout;
      int          cnt;
      logic        ack, ovf, udf;
   } exp_t;

   logic clk = 0;
   always #5 clk = ~clk;

   logic        rst_a, wr_a, rd_a, rst_b, wr_b, rd_b;
   logic [15:0] din_a, din_b, dout_a, dout_b;
   logic        full_a, af_a, empty_a, ae_a, ack_a, ovf_a, udf_a;
   logic        full_b, af_b, empty_b, ae_b, ack_b, ovf_b, udf_b;
   logic [3:0]  cnt_a;
   logic [2:0]  cnt_b;
`ifdef SYNC_FIFO_ERR_CNT_EN
   logic [7:0]  ovf_cnt_a, udf_cnt_a, ovf_cnt_b, udf_cnt_b;
`endif

   sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut_a (
      .clk(clk), .rst_n(rst_a), .wr_en(wr_a), .rd_en(rd_a), .data_in(din_a), .data_out(dout_a),
      .full(full_a), .almostfull(af_a), .empty(empty_a), .almostempty(ae_a),
      .wr_ack(ack_a), .overflow(ovf_a), .underflow(udf_a),
`ifdef SYNC_FIFO_ERR_CNT_EN
      .ovf_cnt(ovf_cnt_a), .udf_cnt(udf_cnt_a),
`endif
      .count(cnt_a));

   sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) dut_b (
      .clk(clk), .rst_n(rst_b), .wr_en(wr_b), .rd_en(rd_b), .data_in(din_b), .data_out(dout_b),
      .full(full_b), .almostfull(af_b), .empty(empty_b), .almostempty(ae_b),
      .wr_ack(ack_b), .overflow(ovf_b), .underflow(udf_b),
`ifdef SYNC_FIFO_ERR_CNT_EN
      .ovf_cnt(ovf_cnt_b), .udf_cnt(udf_cnt_b),
`endif
      .count(cnt_b));

   exp_t q[$];
   int   n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic fifo_flags_t exp_flags(input bit sel, input int cnt);
      int d = sel ? 5 : 8;
      exp_flags.full        = cnt == d;
      exp_flags.almostfull  = cnt >= d - 1 && cnt != d;
      exp_flags.empty       = cnt == 0;
      exp_flags.almostempty = cnt <= 1 && cnt != 0;
   endfunction

   task automatic step(input bit sel, input bit rst, input bit wr, input bit rd, input logic [15:0] din,
                       input logic [15:0] edout, input int ecnt, input bit eack, input bit eovf, input bit eudf);
      exp_t e;
      @(negedge clk);
      rst_a = sel ? 1'b1 : rst; wr_a = sel ? 1'b0 : wr; rd_a = sel ? 1'b0 : rd; din_a = din;
      rst_b = sel ? rst : 1'b1; wr_b = sel ? wr : 1'b0; rd_b = sel ? rd : 1'b0; din_b = din;
      e.sel = sel; e.dout = edout; e.cnt = ecnt; e.ack = eack; e.ovf = eovf; e.udf = eudf;
      q.push_back(e);
   endtask

   // monitor: each record describes the outputs one edge after its stimulus was applied
   initial begin
      exp_t        r;
      fifo_flags_t af;
      forever begin
         @(posedge clk);
         if (q.size() != 0) begin
            r = q.pop_front();
            #2;
            af = r.sel ? fifo_flags_t'({full_b, af_b, empty_b, ae_b}) : fifo_flags_t'({full_a, af_a, empty_a, ae_a});
            chk("data_out", int'(r.sel ? dout_b : dout_a), int'(r.dout));
            chk("count", r.sel ? int'(cnt_b) : int'(cnt_a), r.cnt);
            chk("wr_ack", int'(r.sel ? ack_b : ack_a), int'(r.ack));
            chk("overflow", int'(r.sel ? ovf_b : ovf_a), int'(r.ovf));
            chk("underflow", int'(r.sel ? udf_b : udf_a), int'(r.udf));
            chk("flags", int'(af), int'(exp_flags(r.sel, r.cnt)));
         end
      end
   end

   initial begin
      rst_a = 0; wr_a = 0; rd_a = 0; din_a = 0;
      rst_b = 0; wr_b = 0; rd_b = 0; din_b = 0;
      step(0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) step(0, 1, 1, 0, 16'(i), 16'h0, i, 1, 0, 0);
      step(0, 1, 1, 0, 16'hDEAD, 16'h0, 8, 0, 1, 0);
      for (int i = 1; i <= 8; i++) step(0, 1, 0, 1, 16'h0, 16'(i), 8 - i, 0, 0, 0);
      step(0, 1, 0, 1, 16'h0, 16'h0008, 0, 0, 0, 1);
      step(0, 1, 1, 1, 16'h00AA, 16'h0008, 1, 1, 0, 1);
      step(0, 1, 1, 1, 16'h00BB, 16'h00AA, 1, 1, 0, 0);
      step(0, 1, 1, 0, 16'h0011, 16'h00AA, 2, 1, 0, 0);
      step(0, 1, 1, 0, 16'h0022, 16'h00AA, 3, 1, 0, 0);
      step(0, 1, 1, 0, 16'h0033, 16'h00AA, 4, 1, 0, 0);
      step(0, 1, 1, 0, 16'h0044, 16'h00AA, 5, 1, 0, 0);
      step(0, 1, 1, 0, 16'h0055, 16'h00AA, 6, 1, 0, 0);
      step(0, 1, 1, 0, 16'h0066, 16'h00AA, 7, 1, 0, 0);
      step(0, 1, 1, 0, 16'h0077, 16'h00AA, 8, 1, 0, 0);
      step(0, 1, 1, 1, 16'h00EE, 16'h00BB, 7, 0, 1, 0);
      step(0, 1, 0, 1, 16'h0, 16'h0011, 6, 0, 0, 0);
      step(0, 1, 0, 1, 16'h0, 16'h0022, 5, 0, 0, 0);
      step(0, 1, 0, 1, 16'h0, 16'h0033, 4, 0, 0, 0);
      step(0, 0, 1, 1, 16'h0099, 16'h0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 16'h0, 16'h0, 0, 0, 0, 1);
      for (int i = 0; i < 12; i++) begin
         step(1, 1, 1, 0, 16'h0100 + 16'(i), 16'(i == 0 ? 0 : 16'h0100 + i - 1), 1, 1, 0, 0);
         step(1, 1, 0, 1, 16'h0, 16'h0100 + 16'(i), 0, 0, 0, 0);
      end
`ifdef SYNC_FIFO_ERR_CNT_EN
      step(0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) step(0, 1, 1, 0, 16'h0200 + 16'(i), 16'h0, i, 1, 0, 0);
      for (int i = 0; i < 300; i++) step(0, 1, 1, 0, 16'hBEEF, 16'h0, 8, 0, 1, 0);
`endif
      @(negedge clk);
      rst_a = 1; wr_a = 0; rd_a = 0; rst_b = 1; wr_b = 0; rd_b = 0;
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: %0d records left, expected 0", q.size());
      end
`ifdef SYNC_FIFO_ERR_CNT_EN
      chk("ovf_cnt", int'(ovf_cnt_a), 255);
      chk("udf_cnt", int'(udf_cnt_a), 0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
